dmem_ctrl: RTL and testbench

Parametrised data-memory controller that succeeds the fixed 64-word, always-ready DMEM on the single-cycle datapath. It decodes a CPU byte address against a configurable base, supports byte/halfword/word access with sign or zero extension, inserts a programmable number of wait states, and reports out-of-range and illegal accesses through a request/response handshake. It sits between the CPU's ALU-result/store-data outputs and the on-chip data RAM, in the memory stage of the multi-cycle and pipelined CPU variants.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings, controller FSM states and the load lane-extract/extend helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    // Picks the little-endian lane out of a RAM word; halfword uses lane[1] only, word ignores lane and sgn.
    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = lane[1] ? w[31:16] : w[15:0];
        return sz == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
               sz == SZ_HALF ? {{16{sgn & h[15]}}, h} : w;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH_WORDS x 32 RAM with byte write enables and a read register
// that only updates when re is high, so the last read word is held.
module dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: base-decoded data-memory controller with byte/half/word lanes and programmable wait states.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS_LOAD = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] off_q, off_d, wdata_q, wdata_d;
    logic [1:0]  size_q, size_d, rsize_q, rsize_d, rlane_q, rlane_d;
    logic        we_q, we_d, sgn_q, sgn_d, rsgn_q, rsgn_d, ld_ok_q, ld_ok_d, err_q, err_d;
    logic [31:0] cur_off, cur_wdata, ram_wdata, ram_rdata;
    logic [1:0]  cur_size;
    logic        cur_we, cur_sgn, misalign, fault, enter_done;
    logic [3:0]  be;

    // In IDLE the live request drives decode so a zero-wait access can finish on its accept edge.
    assign cur_off   = state_q == IDLE ? addr - BASE_ADDR : off_q;
    assign cur_wdata = state_q == IDLE ? wdata : wdata_q;
    assign cur_size  = state_q == IDLE ? size : size_q;
    assign cur_we    = state_q == IDLE ? we : we_q;
    assign cur_sgn   = state_q == IDLE ? sign_ext : sgn_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (cur_size == SZ_HALF && cur_off[0]) || (cur_size == SZ_WORD && cur_off[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign fault      = cur_off >= SPAN || cur_size == 2'b11 || misalign;
    assign enter_done = (state_q == IDLE && req && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == 4'd0);
    assign be         = cur_size == SZ_BYTE ? 4'b0001 << cur_off[1:0] :
                        cur_size == SZ_HALF ? (cur_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign ram_wdata  = cur_size == SZ_BYTE ? {4{cur_wdata[7:0]}} :
                        cur_size == SZ_HALF ? {2{cur_wdata[15:0]}} : cur_wdata;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .addr  (cur_off[AW+1:2]),
        .re    (enter_done && !cur_we),
        .be    (enter_done && cur_we && !fault ? be : 4'b0000),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        rsize_d = rsize_q;
        rlane_d = rlane_q;
        rsgn_d  = rsgn_q;
        ld_ok_d = ld_ok_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = WAIT_STATES == 0 ? DONE : WAIT;
                cnt_d   = WS_LOAD;
                off_d   = cur_off;
                wdata_d = wdata;
                size_d  = size;
                we_d    = we;
                sgn_d   = sign_ext;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? DONE : WAIT;
                cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        // Lane selection is captured with the RAM read so rdata holds until the next DONE.
        if (enter_done) begin
            rsize_d = cur_size;
            rlane_d = cur_off[1:0];
            rsgn_d  = cur_sgn;
            ld_ok_d = !cur_we && !fault;
            err_d   = fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            off_q   <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            rsize_q <= 2'd0;
            rlane_q <= 2'd0;
            rsgn_q  <= 1'b0;
            ld_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            sgn_q   <= sgn_d;
            rsize_q <= rsize_d;
            rlane_q <= rlane_d;
            rsgn_q  <= rsgn_d;
            ld_ok_q <= ld_ok_d;
            err_q   <= err_d;
        end
    end

    assign ready  = state_q == IDLE;
    assign rvalid = state_q == DONE;
    assign err    = err_q;
    assign rdata  = ld_ok_q ? load_extend(ram_rdata, rsize_q, rlane_q, rsgn_q) : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and random accesses on a 1-wait-state and a 0-wait-state controller,
// checked against a byte-array memory model.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE_A = 32'h1001_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, we_a, sgn_a, ready_a, rvalid_a, err_a;
    logic [1:0]  size_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, sgn_b, ready_b, rvalid_b, err_b;
    logic [1:0]  size_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [64];

    always #5 clk = ~clk;

    dmem_ctrl #(.BASE_ADDR(BASE_A), .DEPTH_WORDS(64), .WAIT_STATES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .size(size_a), .sign_ext(sgn_a),
        .addr(addr_a), .wdata(wdata_a), .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a)
    );

    dmem_ctrl #(.BASE_ADDR(BASE_B), .DEPTH_WORDS(16), .WAIT_STATES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .size(size_b), .sign_ext(sgn_b),
        .addr(addr_b), .wdata(wdata_b), .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Memory as a flat byte array: faults from range/size/alignment rules, then n bytes little-endian.
    task automatic model(input bit b, input bit we, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit e);
        logic [31:0] off, span, ea, v;
        int n;
        off  = a - (b ? BASE_B : BASE_A);
        span = b ? 32'd64 : 32'd256;
        n    = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        e    = off >= span || sz == 2'd3;
`ifdef DMEM_ALIGN_CHECK_EN
        e = e || (off % n) != 0;
`endif
        ea = off - off % n;
        rd = 32'd0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++)
                    if (b) mem_b[int'(ea) + i] = 8'(wd >> (8 * i));
                    else   mem_a[int'(ea) + i] = 8'(wd >> (8 * i));
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++)
                    v = v | (32'(b ? mem_b[int'(ea) + i] : mem_a[int'(ea) + i]) << (8 * i));
                if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endtask

    task automatic go(input bit we, input logic [1:0] sz, input bit sgn,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        bit          exp_e;
        int          n;
        model(1'b0, we, sz, sgn, a, wd, exp_rd, exp_e);
        @(negedge clk);
        chk("a_ready", 32'(ready_a), 32'd1);
        req_a = 1'b1; we_a = we; size_a = sz; sgn_a = sgn; addr_a = a; wdata_a = wd;
        @(posedge clk);
        #1 req_a = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid_a && n < 20);
        chk("a_latency", 32'(n), 32'd2);
        chk("a_err", 32'(err_a), 32'(exp_e));
        if (!we || exp_e) chk("a_rdata", rdata_a, exp_rd);
        rd = rdata_a;
        @(negedge clk);
        chk("a_pulse", 32'(rvalid_a), 32'd0);
        if (!we || exp_e) chk("a_hold", rdata_a, exp_rd);
    endtask

    task automatic next_b(input int i);
        if (i < 16) begin
            we_b = 1'b1; size_b = 2'd2; sgn_b = 1'b0; addr_b = BASE_B + 32'(4 * i); wdata_b = $urandom;
        end else begin
            we_b = 1'($urandom); size_b = 2'($urandom_range(0, 3)); sgn_b = 1'($urandom);
            addr_b = BASE_B - 32'd4 + 32'($urandom_range(0, 71)); wdata_b = $urandom;
        end
    endtask

    initial begin
        logic [31:0] rd, erd;
        bit          ee;
        rst_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; size_a = 2'd0; sgn_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
        req_b = 1'b0; we_b = 1'b0; size_b = 2'd0; sgn_b = 1'b0; addr_b = 32'd0; wdata_b = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd1);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) go(1'b1, 2'd2, 1'b0, BASE_A + 32'(4 * i), $urandom, rd);
        go(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, rd);
        go(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'd0, rd);
        chk("word_lit", rd, 32'hDEAD_BEEF);
        go(1'b1, 2'd0, 1'b0, 32'h1001_0009, 32'h0000_0080, rd);
        go(1'b0, 2'd0, 1'b1, 32'h1001_0009, 32'd0, rd);
        chk("byte_sx_lit", rd, 32'hFFFF_FF80);
        go(1'b0, 2'd0, 1'b0, 32'h1001_0009, 32'd0, rd);
        chk("byte_zx_lit", rd, 32'h0000_0080);
        go(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'd0, rd);
        chk("merge_lit", rd, 32'hDEAD_80EF);
        go(1'b1, 2'd2, 1'b0, BASE_A, 32'h1111_2222, rd);
        go(1'b1, 2'd2, 1'b0, BASE_A + 32'hFC, 32'h3333_4444, rd);
        go(1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'd0, rd);
        go(1'b0, 2'd2, 1'b0, BASE_A + 32'h100, 32'd0, rd);
        go(1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'h5555_5555, rd);
        go(1'b1, 2'd2, 1'b0, BASE_A + 32'h100, 32'h6666_6666, rd);
        go(1'b0, 2'd2, 1'b0, BASE_A, 32'd0, rd);
        chk("low_bound_lit", rd, 32'h1111_2222);
        go(1'b0, 2'd2, 1'b0, BASE_A + 32'hFC, 32'd0, rd);
        chk("high_bound_lit", rd, 32'h3333_4444);
        go(1'b1, 2'd3, 1'b0, BASE_A + 32'h10, 32'h7777_7777, rd);
        go(1'b1, 2'd2, 1'b0, 32'h1001_0002, 32'hCAFE_F00D, rd);
        go(1'b0, 2'd2, 1'b0, BASE_A, 32'd0, rd);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("align_lit", rd, 32'h1111_2222);
`else
        chk("align_lit", rd, 32'hCAFE_F00D);
`endif
        for (int i = 0; i < 150; i++)
            go(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
               BASE_A - 32'd8 + 32'($urandom_range(0, 271)), $urandom, rd);
        @(negedge clk);
        next_b(0);
        req_b = 1'b1;
        for (int i = 0; i < 48; i++) begin
            chk("b_ready_idle", 32'(ready_b), 32'd1);
            chk("b_rvalid_idle", 32'(rvalid_b), 32'd0);
            model(1'b1, we_b, size_b, sgn_b, addr_b, wdata_b, erd, ee);
            @(negedge clk);
            chk("b_ready_done", 32'(ready_b), 32'd0);
            chk("b_rvalid_done", 32'(rvalid_b), 32'd1);
            chk("b_err", 32'(err_b), 32'(ee));
            if (!we_b || ee) chk("b_rdata", rdata_b, erd);
            next_b(i + 1);
            @(negedge clk);
        end
        req_b = 1'b0;
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; size_a = 2'd2; sgn_a = 1'b0; addr_a = 32'h1001_0010; wdata_a = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 req_a = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(rvalid_a), 32'd0);
        chk("rst_mid_ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_pulse", 32'(rvalid_a), 32'd0);
        end
        go(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'd0, rd);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
